dp_issue_stage: RTL and testbench

Issue stage directly upstream of `datapath`. Accepts encoded instructions over a valid/ready handshake and reads four 4-bit operands from an internal 8-entry register file. It presents op/form/vec/operands/zero_reg/write to `datapath` for one issue cycle, then writes `Y1`/`Y2` back into the register file after a fixed datapath latency. It also keeps a retired-instruction counter and a debug read port for benches.

---
 rtl/dp_issue_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_dp_issue_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : dp_issue_stage
// Purpose  : Issue stage in front of the datapath. It accepts an instruction,
//            reads operands from an 8x4 register file and issues them for one
//            cycle. After DP_LATENCY cycles it writes Y1/Y2 back to the
//            register file and counts the instruction as retired.
// Options  : ISSUE_BYPASS_EN - accept in WB and forward writeback values
// Revision : 1.0 - initial release
// ============================================================================
module dp_issue_stage #(
    parameter int DP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [25:0] in_instr,
    output logic        issue,
    output logic [2:0]  op,
    output logic        form,
    output logic [1:0]  vec,
    output logic [1:0]  write,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [3:0]  C,
    output logic [3:0]  D,
    output logic [3:0]  zero_reg,
    input  logic [3:0]  Y1,
    input  logic [3:0]  Y2,
    input  logic [2:0]  dbg_idx,
    output logic [3:0]  dbg_data,
    output logic [15:0] retired
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    localparam logic [2:0] C_WAIT_LAST = 3'(DP_LATENCY - 1);
    localparam bit         C_HAS_WAIT  = (DP_LATENCY > 1);

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;

    logic        w_ready;
    logic        w_accept;
    logic        w_issue;
    logic        w_wb;
    logic        w_we1;
    logic        w_we2;

    logic [3:0]  rf_q [8];
    logic [2:0]  w_src [4];
    logic [3:0]  w_opnd [4];
    logic [3:0]  w_zero;

    logic [2:0]  op_q;
    logic        form_q;
    logic [1:0]  vec_q;
    logic [1:0]  write_q;
    logic [2:0]  dst1_q;
    logic [2:0]  dst2_q;
    logic [3:0]  opnd_q [4];
    logic [3:0]  zero_q;
    logic [15:0] retired_q;

    assign w_src[0] = in_instr[17:15];
    assign w_src[1] = in_instr[14:12];
    assign w_src[2] = in_instr[11:9];
    assign w_src[3] = in_instr[8:6];

    assign w_accept = in_valid & w_ready;

    // r0 is never written, so writes to it are filtered here
    assign w_we1 = w_wb & write_q[0] & (dst1_q != 3'd0);
    assign w_we2 = w_wb & write_q[1] & (dst2_q != 3'd0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (C_HAS_WAIT) begin
                    state_d = S_WAIT;
                    cnt_d   = 3'd1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WAIT: begin
                // WAIT spans DP_LATENCY-1 cycles; cnt_q numbers them from 1
                if (cnt_q >= C_WAIT_LAST) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WB: begin
                state_d = w_accept ? S_ISSUE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_issue = (state_q == S_ISSUE);
        w_wb    = (state_q == S_WB);
`ifdef ISSUE_BYPASS_EN
        w_ready = (state_q == S_IDLE) || (state_q == S_WB);
`else
        w_ready = (state_q == S_IDLE);
`endif
    end

    // ------------------------------------------------------------------
    // Operand read, with forwarding of the same-edge writeback if enabled
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_opnd[i] = rf_q[w_src[i]];
            w_zero[i] = (w_src[i] == 3'd0);
`ifdef ISSUE_BYPASS_EN
            if (w_we1 && (dst1_q == w_src[i])) begin
                w_opnd[i] = Y1;
            end
            // Y2 checked last so it wins a dst1==dst2 collision
            if (w_we2 && (dst2_q == w_src[i])) begin
                w_opnd[i] = Y2;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Instruction capture; held until the next accept
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 3'd0;
            form_q  <= 1'b0;
            vec_q   <= 2'd0;
            write_q <= 2'd0;
            dst1_q  <= 3'd0;
            dst2_q  <= 3'd0;
            zero_q  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                opnd_q[i] <= 4'd0;
            end
        end else if (w_accept) begin
            op_q    <= in_instr[25:23];
            form_q  <= in_instr[22];
            vec_q   <= in_instr[21:20];
            write_q <= in_instr[19:18];
            dst1_q  <= in_instr[5:3];
            dst2_q  <= in_instr[2:0];
            zero_q  <= w_zero;
            for (int i = 0; i < 4; i++) begin
                opnd_q[i] <= w_opnd[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file writeback and retired counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 4'd0;
            end
            retired_q <= 16'd0;
        end else if (w_wb) begin
            if (w_we1) begin
                rf_q[dst1_q] <= Y1;
            end
            if (w_we2) begin
                rf_q[dst2_q] <= Y2;
            end
            retired_q <= retired_q + 16'd1;
        end
    end

    assign in_ready = w_ready;
    assign issue    = w_issue;
    assign op       = op_q;
    assign form     = form_q;
    assign vec      = vec_q;
    assign write    = write_q;
    assign A        = opnd_q[0];
    assign B        = opnd_q[1];
    assign C        = opnd_q[2];
    assign D        = opnd_q[3];
    assign zero_reg = zero_q;
    assign dbg_data = rf_q[dbg_idx];
    assign retired  = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_issue_stage
// Purpose  : Self-checking bench for dp_issue_stage against a cycle-indexed
//            behavioural model (ISSUE_BYPASS_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_issue_stage;

    localparam int L = 3;
`ifdef ISSUE_BYPASS_EN
    localparam int GAP = L + 1;
    localparam bit BYP = 1'b1;
`else
    localparam int GAP = L + 2;
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [25:0] in_instr = '0;
    logic [3:0]  Y1 = '0;
    logic [3:0]  Y2 = '0;
    logic [2:0]  dbg_idx = '0;
    logic        in_ready, issue, form;
    logic [2:0]  op;
    logic [1:0]  vec, write;
    logic [3:0]  A, B, C, D, zero_reg, dbg_data;
    logic [15:0] retired;

    dp_issue_stage #(.DP_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .issue(issue), .op(op), .form(form), .vec(vec),
        .write(write), .A(A), .B(B), .C(C), .D(D), .zero_reg(zero_reg),
        .Y1(Y1), .Y2(Y2), .dbg_idx(dbg_idx), .dbg_data(dbg_data),
        .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: everything indexed by the absolute edge/cycle number cyc
    logic [3:0]  mrf [8];
    logic [2:0]  m_op, m_d1, m_d2;
    logic        m_form;
    logic [1:0]  m_vec, m_wr;
    logic [3:0]  m_opnd [4];
    logic [3:0]  m_zero;
    logic [15:0] m_ret;
    int          cyc = 0;
    int          next_ok = 0;
    int          issue_cyc = -100;
    int          wb_cyc = -100;
    bit          pending = 1'b0;
    bit          acc_now = 1'b0;
    int          dut_iss_cnt = 0;
    int          dut_iss_last = 0;
    int          dut_iss_prev = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mrf[i] = 4'd0;
        m_op = 0; m_form = 0; m_vec = 0; m_wr = 0; m_d1 = 0; m_d2 = 0;
        for (int i = 0; i < 4; i++) m_opnd[i] = 4'd0;
        m_zero = 0; m_ret = 0; pending = 0; acc_now = 0;
        issue_cyc = -100; wb_cyc = -100;
    endtask

    // Called just after edge number cyc, with the inputs that were sampled there
    task automatic model_edge();
        logic [2:0] s [4];
        acc_now = 1'b0;
        if (pending && (wb_cyc == cyc - 1)) begin
            if (m_wr[0] && m_d1 != 3'd0) mrf[m_d1] = Y1;
            if (m_wr[1] && m_d2 != 3'd0) mrf[m_d2] = Y2;
            m_ret   = m_ret + 16'd1;
            pending = 1'b0;
        end
        if (in_valid && (cyc - 1 >= next_ok)) begin
            s[0] = in_instr[17:15]; s[1] = in_instr[14:12];
            s[2] = in_instr[11:9];  s[3] = in_instr[8:6];
            m_op = in_instr[25:23]; m_form = in_instr[22];
            m_vec = in_instr[21:20]; m_wr = in_instr[19:18];
            m_d1 = in_instr[5:3]; m_d2 = in_instr[2:0];
            for (int i = 0; i < 4; i++) begin
                m_opnd[i] = mrf[s[i]];
                m_zero[i] = (s[i] == 3'd0);
            end
            issue_cyc = cyc;
            wb_cyc    = cyc + L;
            next_ok   = BYP ? cyc + L : cyc + L + 1;
            pending   = 1'b1;
            acc_now   = 1'b1;
        end
    endtask

    task automatic compare();
        if (issue === 1'b1) begin
            dut_iss_prev = dut_iss_last;
            dut_iss_last = cyc;
            dut_iss_cnt++;
        end
        chk("in_ready", in_ready, 16'(cyc >= next_ok));
        chk("issue", issue, 16'(cyc == issue_cyc));
        chk("op", op, m_op);
        chk("form", form, m_form);
        chk("vec", vec, m_vec);
        chk("write", write, m_wr);
        chk("A", A, m_opnd[0]);
        chk("B", B, m_opnd[1]);
        chk("C", C, m_opnd[2]);
        chk("D", D, m_opnd[3]);
        chk("zero_reg", zero_reg, m_zero);
        chk("retired", retired, m_ret);
        chk("dbg_data", dbg_data, mrf[dbg_idx]);
    endtask

    // Entered just after an edge; returns just after the following edge
    task automatic cyc_step(input logic v, input logic [25:0] ins,
                            input logic [3:0] y1, input logic [3:0] y2, input logic [2:0] di);
        in_valid = v; in_instr = ins; Y1 = y1; Y2 = y2; dbg_idx = di;
        #4;
        compare();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #1;
        chk("rst_async_ready", in_ready, 16'd1);
        chk("rst_async_issue", issue, 16'd0);
        chk("rst_async_retired", retired, 16'd0);
        chk("rst_async_A", A, 16'd0);
        chk("rst_async_op", op, 16'd0);
        repeat (hold) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        rst = 1'b0;
        next_ok = cyc;
    endtask

    task automatic send(input logic [25:0] ins, input logic [3:0] y1, input logic [3:0] y2);
        int n = 0;
        do begin
            cyc_step(1'b1, ins, y1, y2, 3'($urandom));
            n++;
        end while (!acc_now && n < 30);
        if (!acc_now) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=none required=accept cycle=%0d", cyc);
        end
    endtask

    task automatic drain(input logic [3:0] y1, input logic [3:0] y2);
        int n = 0;
        while (pending && n < 30) begin
            cyc_step(1'b0, 26'($urandom), y1, y2, 3'($urandom));
            n++;
        end
    endtask

    task automatic peek(input string name, input logic [2:0] idx, input logic [3:0] exp);
        cyc_step(1'b0, 26'd0, 4'd0, 4'd0, idx);
        chk(name, dbg_data, exp);
    endtask

    function automatic logic [25:0] mk(input int o, input int f, input int v, input int w,
                                       input int sa, input int sb, input int sc, input int sd,
                                       input int d1, input int d2);
        return {3'(o), 1'(f), 2'(v), 2'(w), 3'(sa), 3'(sb), 3'(sc), 3'(sd), 3'(d1), 3'(d2)};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int c0;
        #1;
        do_reset(3);
        chk("reset_ready", in_ready, 16'd1);
        chk("reset_retired", retired, 16'd0);
        for (int i = 0; i < 8; i++) peek("reset_dbg", 3'(i), 4'd0);

        // Reset during WAIT abandons the instruction
        send(mk(5, 1, 2, 1, 1, 2, 3, 4, 7, 0), 4'hB, 4'h0);
        cyc_step(1'b0, 26'd0, 4'hB, 4'h0, 3'd7);
        do_reset(2);
        peek("midrst_r7", 3'd7, 4'h0);
        chk("midrst_retired", retired, 16'd0);
        chk("midrst_ready", in_ready, 16'd1);

        // Single instruction, two writes
        c0 = dut_iss_cnt;
        send(mk(0, 0, 0, 3, 0, 0, 0, 0, 3, 5), 4'hA, 4'h6);
        drain(4'hA, 4'h6);
        chk("t1_issue_pulses", 16'(dut_iss_cnt - c0), 16'd1);
        peek("t1_r3", 3'd3, 4'hA);
        peek("t1_r5", 3'd5, 4'h6);
        chk("t1_retired", retired, 16'd1);

        // Operand read and zero flags
        send(mk(1, 0, 0, 3, 0, 0, 0, 0, 2, 4), 4'h7, 4'h3);
        drain(4'h7, 4'h3);
        send(mk(2, 1, 1, 0, 2, 0, 4, 0, 1, 1), 4'h0, 4'h0);
        chk("t2_A", A, 16'h7);
        chk("t2_B", B, 16'h0);
        chk("t2_C", C, 16'h3);
        chk("t2_D", D, 16'h0);
        chk("t2_zero", zero_reg, 16'b1010);
        drain(4'h0, 4'h0);

        // Write collision and r0 drop
        send(mk(3, 0, 0, 3, 0, 0, 0, 0, 6, 6), 4'h1, 4'h9);
        drain(4'h1, 4'h9);
        peek("t3_r6", 3'd6, 4'h9);
        send(mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 2), 4'hF, 4'h0);
        drain(4'hF, 4'h0);
        peek("t3_r0", 3'd0, 4'h0);
        peek("t3_r2", 3'd2, 4'h7);

        // Back-to-back dependency with in_valid held high
        send(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0), 4'hC, 4'hC);
        send(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 4'hC, 4'hC);
        chk("b2b_A", A, 16'hC);
        drain(4'hC, 4'hC);
        chk("b2b_gap", 16'(dut_iss_last - dut_iss_prev), 16'(GAP));

        // Random traffic, with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset(2);
            cyc_step(1'($urandom_range(0, 3) != 0), 26'($urandom),
                     4'($urandom), 4'($urandom), 3'($urandom));
        end
        drain(4'h5, 4'hA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
